// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the I/D port arbiter. The arbiter is the master and
// the unified single-port memory is the slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_be;
  logic                  m_ack;
  logic [DATA_W-1:0]     m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch (I) and
// load/store (D). D wins ties unless I has lost STARVE_LIMIT arbitrations in
// a row; a hung access is aborted after TIMEOUT busy cycles with an error.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  mem_port_arbiter_if.master  mem,
  output logic                busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]          state_q, state_d;
  logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W/8-1:0] m_be_q, m_be_d;
  logic                i_done_q, i_done_d;
  logic                i_err_q, i_err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                d_done_q, d_done_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;

  logic starved;
  assign starved = (starve_cnt_q == SW'(STARVE_LIMIT));

  // Next-state: arbitration in IDLE, completion/timeout in BUSY_x, one-cycle RESP.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    i_done_d     = 1'b0;
    i_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_done_d     = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (d_req && !(i_req && starved)) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          // D can only win a contested round while starve_cnt is below the limit.
          if (i_req) starve_cnt_d = starve_cnt_q + SW'(1);
        end else if (i_req) begin
          state_d      = BUSY_I;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
          m_be_d       = '1;
          starve_cnt_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem.m_ack) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          tmo_cnt_d = '0;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem.m_rdata;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = mem.m_rdata;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          tmo_cnt_d = '0;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_err_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronously reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      i_done_q     <= 1'b0;
      i_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_done_q     <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
      i_done_q     <= i_done_d;
      i_err_q      <= i_err_d;
      i_rdata_q    <= i_rdata_d;
      d_done_q     <= d_done_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem.m_req   = m_req_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wdata = m_wdata_q;
  assign mem.m_be    = m_be_q;
  assign i_done      = i_done_q;
  assign i_err       = i_err_q;
  assign i_rdata     = i_rdata_q;
  assign d_done      = d_done_q;
  assign d_err       = d_err_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the fetch/memory stages and the unified memory.
- Data requests have priority, since they belong to the older instruction. A starvation counter guarantees fetch progress.
- A bus timeout converts a hung access into an error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which I wins the next arbitration.
- TIMEOUT, 255, BUSY cycles without m_ack before the access is aborted with error (must be ≥1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_done  out  1  one-cycle fetch completion pulse.
- i_err  out  1  valid with i_done; 1 means timeout.
- i_rdata  out  DATA_W  fetch data; valid while i_done=1.
- d_req  in  1  load/store request; held with its fields stable until d_done.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_done  out  1  one-cycle data completion pulse.
- d_err  out  1  valid with d_done; 1 means timeout.
- d_rdata  out  DATA_W  load data; valid while d_done=1.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_be  out  DATA_W/8  memory byte enables.
- m_ack  in  1  memory completion; ignored unless m_req=1.
- m_rdata  in  DATA_W  memory read data; valid with m_ack.
- busy  out  1  state is not IDLE.

Behaviour:
- All outputs are registered.
- On rst:
  - state=IDLE, starve_cnt=0, tmo_cnt=0.
  - m_req, m_we, i_done, d_done, i_err, d_err, busy all 0.
  - m_addr, m_wdata, m_be, i_rdata, d_rdata all 0.
- Reset mid-access drops m_req the next cycle. The memory shares rst, so no stale m_ack is delivered.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both requests: grant D, unless starve_cnt==STARVE_LIMIT, in which case grant I.
  - On grant: latch the winner's fields into m_*, set m_req=1, set m_we=d_we for D and 0 for I, set m_be all-ones for I. Go to BUSY_x.
- starve_cnt:
  - +1 when both request and D wins.
  - Cleared when I is granted.
  - Saturates at STARVE_LIMIT.
- BUSY_x:
  - m_req=1 and m_* are stable. tmo_cnt increments every cycle.
  - On m_ack: capture m_rdata into x_rdata, drop m_req, clear tmo_cnt, go to RESP with x_done=1 and x_err=0 on the next cycle.
  - If tmo_cnt==TIMEOUT-1 without m_ack: drop m_req, go to RESP with x_done=1, x_err=1, x_rdata=0.
- RESP:
  - Exactly one cycle. No arbitration; done/err are cleared on exit. Next state IDLE.
  - The requester deasserts or renews its req at this edge.
- Latency from req high in IDLE with m_ack in the first BUSY cycle:
  - cycle 0: req sampled;
  - cycle 1: m_req=1 and m_ack;
  - cycle 2: done.
  - Each extra memory wait cycle adds 1.
- Throughput: at most one access per 3 cycles.
- Stores return d_rdata as captured from m_rdata (don't-care to requester).
- Never: i_done and d_done high together; done for a requester not granted; m_* change while m_req=1.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, memory acks in the first BUSY cycle with 0x00500093.
  -> m_req high in cycle 1 with m_addr=0x100 and m_we=0; i_done=1 and i_rdata=0x00500093 in cycle 2; busy low in cycle 3.
- Store priority: i_req and d_req rise together, with d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF.
  -> D is served first with m_we=1 and m_wdata=0xDEADBEEF; d_done precedes i_done; I is served immediately after.
- Starvation: d_req held continuously (renewed after each done) while i_req=1, STARVE_LIMIT=4.
  -> exactly 4 D accesses, then an I access, then starve_cnt is 0 and D resumes.
- Timeout: TIMEOUT=8, d_req issued, m_ack never asserted.
  -> m_req high for exactly 8 cycles, then d_done=1 with d_err=1 and d_rdata=0; the next access completes normally with err=0.
- Reset mid-access: rst=1 while in BUSY_D with m_ack delayed.
  -> the next cycle has m_req=0, busy=0, both done=0, starve_cnt=0; a fresh i_req after reset completes with 2-cycle latency.
